// File: rtl/adc_cfg_pkg.sv
// Shared types and constants for the ADC serial configuration port.
package adc_cfg_pkg;

  localparam int WORD_W = 24;
  localparam int RW_BIT = WORD_W - 1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RST_LOW,
    ST_RST_REC,
    ST_FETCH,
    ST_FRAME,
    ST_GAP
  } seq_state_e;

endpackage

// File: rtl/adc_spi_shifter.sv
// Mode-0 serial shifter: one WORD_W frame per start pulse, MSB first, done on CSN rise.
module adc_spi_shifter
  import adc_cfg_pkg::*;
#(
  parameter int WORD_W  = adc_cfg_pkg::WORD_W,
  parameter int CLK_DIV = 10
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [WORD_W-1:0] word,
  output logic              done,
  output logic              sclk,
  output logic              csn,
  output logic              mosi
);

  localparam int DIV_W = $clog2(CLK_DIV) + 1;
  localparam logic [DIV_W-1:0] DIV_RELOAD = DIV_W'(CLK_DIV - 1);
  localparam logic [4:0] LAST_BIT = 5'(WORD_W - 1);

  logic [WORD_W-1:0] shreg;
  logic [4:0]        bit_cnt;
  logic [DIV_W-1:0]  div_cnt;
  logic              active;
  logic              tail;
  logic              bit_adv;

  // MOSI only moves at the end of a high phase, i.e. on the SCLK fall.
  assign bit_adv = active && !start && (div_cnt == '0) && !tail && sclk && (bit_cnt != LAST_BIT);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      active  <= 1'b0;
      tail    <= 1'b0;
      done    <= 1'b0;
      sclk    <= 1'b0;
      csn     <= 1'b1;
      mosi    <= 1'b0;
      bit_cnt <= '0;
      div_cnt <= '0;
    end else begin
      done <= 1'b0;
      if (start) begin
        active  <= 1'b1;
        tail    <= 1'b0;
        csn     <= 1'b0;
        sclk    <= 1'b0;
        mosi    <= word[WORD_W-1];
        bit_cnt <= '0;
        div_cnt <= DIV_RELOAD;
      end else if (active) begin
        if (div_cnt != '0) begin
          div_cnt <= div_cnt - 1'b1;
        end else if (tail) begin
          csn    <= 1'b1;
          active <= 1'b0;
          tail   <= 1'b0;
          done   <= 1'b1;
        end else if (!sclk) begin
          sclk    <= 1'b1;
          div_cnt <= DIV_RELOAD;
        end else begin
          sclk    <= 1'b0;
          div_cnt <= DIV_RELOAD;
          if (bit_cnt == LAST_BIT) begin
            tail <= 1'b1;
          end else begin
            bit_cnt <= bit_cnt + 1'b1;
            mosi    <= shreg[WORD_W-1];
          end
        end
      end
    end
  end

  // Data path register: no reset, contents are always reloaded by start.
  always_ff @(posedge clk) begin
    if (start) begin
      shreg <= {word[WORD_W-2:0], 1'b0};
    end else if (bit_adv) begin
      shreg <= {shreg[WORD_W-2:0], 1'b0};
    end
  end

endmodule

// File: rtl/adc_cfg_sequencer.sv
// ADC configuration port owner: boot reset pulse + init table, then arbitrated host writes.
module adc_cfg_sequencer #(
  parameter int WORD_W     = adc_cfg_pkg::WORD_W,
  parameter int CLK_DIV    = 10,
  parameter int NUM_INIT   = 8,
  parameter int ADDR_W     = 3,
  parameter int RST_CYCLES = 100,
  parameter int CS_GAP     = 4
) (
  input  logic              adc_set_clk,
  input  logic              adc_rstn,
  input  logic              start_init,
  input  logic              host_req,
  input  logic [WORD_W-1:0] host_word,
  output logic              host_ack,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [WORD_W-1:0] rom_data,
  output logic              busy,
  output logic              init_done,
  output logic              ADC_SCLK,
  output logic              ADC_CSN,
  output logic              ADC_MOSI,
  output logic              ADC_RSTN
);

  import adc_cfg_pkg::*;

  localparam int TMR_W = $clog2(RST_CYCLES + CS_GAP + 2);

  seq_state_e        state_q, state_d;
  logic [TMR_W-1:0]  tmr_q, tmr_d;
  logic [ADDR_W-1:0] addr_d;
  logic              ack_d, rstn_pin_d, done_d;
  logic              run_q, run_d;
  logic              shf_start, shf_done;
  logic [WORD_W-1:0] shf_word;

  always_ff @(posedge adc_set_clk or negedge adc_rstn) begin
    if (!adc_rstn) begin
      state_q   <= ST_IDLE;
      tmr_q     <= '0;
      rom_addr  <= '0;
      host_ack  <= 1'b0;
      ADC_RSTN  <= 1'b1;
      init_done <= 1'b0;
      run_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      tmr_q     <= tmr_d;
      rom_addr  <= addr_d;
      host_ack  <= ack_d;
      ADC_RSTN  <= rstn_pin_d;
      init_done <= done_d;
      run_q     <= run_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    tmr_d      = tmr_q;
    addr_d     = rom_addr;
    ack_d      = 1'b0;
    rstn_pin_d = ADC_RSTN;
    done_d     = init_done;
    run_d      = run_q;
    shf_start  = 1'b0;
    shf_word   = host_word;
    case (state_q)
      // start_init has priority; a simultaneous host_req simply stays pending.
      ST_IDLE: begin
        if (start_init) begin
          state_d    = ST_RST_LOW;
          tmr_d      = TMR_W'(RST_CYCLES - 1);
          rstn_pin_d = 1'b0;
          done_d     = 1'b0;
          run_d      = 1'b1;
        end else if (host_req) begin
          state_d   = ST_FRAME;
          ack_d     = 1'b1;
          shf_start = 1'b1;
        end
      end
      ST_RST_LOW: begin
        if (tmr_q == '0) begin
          state_d    = ST_RST_REC;
          tmr_d      = TMR_W'(RST_CYCLES - 1);
          rstn_pin_d = 1'b1;
        end else begin
          tmr_d = tmr_q - 1'b1;
        end
      end
      ST_RST_REC: begin
        if (tmr_q == '0) begin
          state_d = ST_FETCH;
          addr_d  = '0;
        end else begin
          tmr_d = tmr_q - 1'b1;
        end
      end
      // First cycle lets the synchronous table catch up with rom_addr.
      ST_FETCH: begin
        if (tmr_q == '0) begin
          tmr_d = TMR_W'(1);
        end else begin
          shf_start = 1'b1;
          shf_word  = rom_data;
          state_d   = ST_FRAME;
        end
      end
      ST_FRAME: begin
        if (shf_done) begin
          state_d = ST_GAP;
          tmr_d   = TMR_W'(CS_GAP - 1);
        end
      end
      ST_GAP: begin
        if (tmr_q != '0) begin
          tmr_d = tmr_q - 1'b1;
        end else if (run_q && (rom_addr < ADDR_W'(NUM_INIT - 1))) begin
          state_d = ST_FETCH;
          addr_d  = rom_addr + 1'b1;
        end else begin
          state_d = ST_IDLE;
          if (run_q) begin
            done_d = 1'b1;
            run_d  = 1'b0;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign busy = (state_q != ST_IDLE);

  adc_spi_shifter #(
    .WORD_W  (WORD_W),
    .CLK_DIV (CLK_DIV)
  ) u_shifter (
    .clk   (adc_set_clk),
    .rst_n (adc_rstn),
    .start (shf_start),
    .word  (shf_word),
    .done  (shf_done),
    .sclk  (ADC_SCLK),
    .csn   (ADC_CSN),
    .mosi  (ADC_MOSI)
  );

endmodule
